irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Parametrised interrupt controller between the debounced button/peripheral request lines and PCPU.
//  Replaces fixed interrupt_one/interrupt_two wiring with NUM_IRQ maskable channels.
//  Each channel has a synchroniser, rising-edge capture, pending latch and overflow flag.
//  Requests are fixed-priority encoded into one request/vector/ack handshake with the CPU.
// PARAMETERS
//  NUM_IRQ      8      number of request channels (2..32)
//  VEC_W        3      vector width, must equal $clog2(NUM_IRQ)
//  SYNC_STAGES  2      synchroniser flops per channel (>=2)
//  MASK_RESET   0      reset value of mask register (1 = masked)
// PORTS
//  clk          in   1        CPU clock (clk_cpu domain)
//  rst          in   1        synchronous reset, active-high
//  irq_in       in   NUM_IRQ  raw request lines, asynchronous, level, rising edge = event
//  mask_we      in   1        write strobe for mask register
//  mask_wdata   in   NUM_IRQ  new mask value
//  ovf_clr      in   NUM_IRQ  per-channel overflow clear strobe
//  int_ack      in   1        CPU accepts current int_vec (1-cycle pulse)
//  int_eret     in   1        CPU returns from handler (1-cycle pulse)
//  int_req      out  1        interrupt request to CPU, registered
//  int_vec      out  VEC_W    channel index of int_req, registered
//  mask         out  NUM_IRQ  current mask register
//  pending      out  NUM_IRQ  pending latches
//  overflow     out  NUM_IRQ  sticky: edge arrived while channel already pending
//  in_service   out  1        a handler is active
// BEHAVIOUR
//  Reset: all sync flops, pending, overflow, in_service, int_req = 0; int_vec = 0; mask = MASK_RESET.
//  Capture: edge = sync[S-1] & ~prev. Sets pending the following clk.
//   irq_in high before edge 1 gives int_req high after edge SYNC_STAGES+2 (edge 4 for S=2).
//  Same-cycle edge and ack clear on the same channel: pending stays 1 (set wins), overflow unchanged.
//  Edge on a channel with pending=1 and no same-cycle clear: pending stays 1, overflow set.
//   overflow clears only via ovf_clr; set wins over ovf_clr in the same cycle.
//  Selection: eligible = pending & ~mask. The lowest eligible index wins.
//   int_req/int_vec are registered from eligible and in-service state, giving 1-cycle latency.
//   int_vec holds its last value while int_req = 0.
//  Handshake: int_ack is honoured only while int_req = 1. On ack:
//   pending[int_vec] clears, in-service state records int_vec, int_req = 0 the next cycle.
//   int_ack while int_req = 0 is ignored with no state change.
//  int_eret with nothing in service is ignored.
//   eret releases service; the next eligible channel raises int_req 1 cycle later.
//  Masking: masked channels still capture edges and keep pending.
//   Unmasking a pending channel raises int_req 1 cycle after the mask write.
//   mask_we in the same cycle as an ack has no effect on that ack.
//  rst mid-handshake: all state clears immediately; in-flight ack/eret are discarded.
// CONFIGURATION
//  IRQ_NEST_EN undefined: single-level.
//   in_service is one flag; int_req is forced 0 while in_service = 1.
//  IRQ_NEST_EN defined: nesting via an NUM_IRQ-bit in-service bitmap.
//   int_req is asserted when the best eligible index < lowest set in-service bit.
//   eret clears the lowest set in-service bit; in_service = |bitmap.
//   An equal or lower priority request waits until eret.
// TESTING
//  T1 reset: rst=1 for 2 cycles, MASK_RESET=0 -> int_req=0, pending=0, mask=0, in_service=0.
//  T2 single: pulse irq_in[5] -> int_req=1, int_vec=5 after edge 4.
//   ack -> pending[5]=0, in_service=1, int_req=0. eret -> in_service=0.
//  T3 priority: irq_in[6] and [2] together -> int_vec=2.
//   ack, eret -> int_vec=6 one cycle after eret.
//  T4 mask: mask=8'h08, edge on irq_in[3] -> pending[3]=1, int_req=0.
//   write mask=0 -> int_req=1, int_vec=3 next cycle.
//  T5 overflow: two edges on irq_in[1] before ack -> overflow[1]=1.
//   ovf_clr[1] -> overflow[1]=0. Bogus ack with int_req=0 -> no change.
//  T6 nest (IRQ_NEST_EN): service ch4, then edge ch1 -> int_req=1, int_vec=1.
//   Edge ch7 -> held. Two erets -> ch7 raised.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: NUM_IRQ-channel maskable interrupt controller with a fixed-priority CPU handshake.
// Define IRQ_NEST_EN to enable nested service via an in-service bitmap (default: single level).
module irq_ctrl #(
  parameter int                 NUM_IRQ     = 8,
  parameter int                 VEC_W       = 3,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [NUM_IRQ-1:0] MASK_RESET  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic [NUM_IRQ-1:0] ovf_clr,
  input  logic               int_ack,
  input  logic               int_eret,
  output logic               int_req,
  output logic [VEC_W-1:0]   int_vec,
  output logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] overflow,
  output logic               in_service
);

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] overflow_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic [VEC_W-1:0]   best;
  logic [VEC_W-1:0]   int_vec_q;
  logic               any_elig;
  logic               allow;
  logic               ack_fire;
  logic               req_d;
  logic               int_req_q;

  assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign eligible = pending_q & ~mask_q;
  assign ack_fire = int_ack & int_req_q;
  assign req_d    = any_elig & allow & ~ack_fire;

  always_comb begin
    best     = '0;
    any_elig = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        best     = VEC_W'(i);
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    ack_clr          = '0;
    ack_clr[int_vec_q] = ack_fire;
  end

`ifdef IRQ_NEST_EN
  logic [NUM_IRQ-1:0] svc_q;
  logic [VEC_W-1:0]   svc_idx;

  always_comb begin
    svc_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (svc_q[i]) svc_idx = VEC_W'(i);
    end
  end

  // Only a strictly higher-priority (lower index) request may preempt the active handlers.
  assign allow      = (svc_q == '0) || (best < svc_idx);
  assign in_service = |svc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      svc_q <= '0;
    end else begin
      svc_q <= (int_eret ? (svc_q & (svc_q - NUM_IRQ'(1))) : svc_q) | ack_clr;
    end
  end
`else
  logic svc_q;

  assign allow      = ~svc_q;
  assign in_service = svc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      svc_q <= 1'b0;
    end else if (ack_fire) begin
      svc_q <= 1'b1;
    end else if (int_eret) begin
      svc_q <= 1'b0;
    end
  end
`endif

  // A fresh edge beats a same-cycle ack clear; overflow set beats ovf_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      prev_q     <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
      mask_q     <= MASK_RESET;
      int_req_q  <= 1'b0;
      int_vec_q  <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], irq_in};
      prev_q     <= sync_q[SYNC_STAGES-1];
      pending_q  <= (pending_q & ~ack_clr) | rise;
      overflow_q <= (overflow_q & ~ovf_clr) | (rise & pending_q & ~ack_clr);
      if (mask_we) mask_q <= mask_wdata;
      int_req_q  <= req_d;
      if (req_d) int_vec_q <= best;
    end
  end

  assign int_req  = int_req_q;
  assign int_vec  = int_vec_q;
  assign mask     = mask_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl (8 channels, 2 sync stages).
// Nesting scenario is built only when IRQ_NEST_EN is defined.
module tb_irq_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic [7:0] ovf_clr;
  logic       int_ack;
  logic       int_eret;
  logic       int_req;
  logic [2:0] int_vec;
  logic [7:0] mask;
  logic [7:0] pending;
  logic [7:0] overflow;
  logic       in_service;

  int tests_run = 0;
  int tests_failed = 0;

  irq_ctrl #(
    .NUM_IRQ(8), .VEC_W(3), .SYNC_STAGES(2), .MASK_RESET(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .ovf_clr(ovf_clr), .int_ack(int_ack), .int_eret(int_eret), .int_req(int_req),
    .int_vec(int_vec), .mask(mask), .pending(pending), .overflow(overflow),
    .in_service(in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_irq(input int idx);
    irq_in[idx] = 1'b1;
    step(1);
    irq_in[idx] = 1'b0;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
  endtask

  task automatic do_eret();
    int_eret = 1'b1;
    step(1);
    int_eret = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    step(1);
    mask_we    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
    ovf_clr = '0; int_ack = 1'b0; int_eret = 1'b0;

    // T1 reset
    step(2);
    rst = 1'b0;
    check_output("t1_int_req", 32'(int_req), 0);
    check_output("t1_pending", 32'(pending), 0);
    check_output("t1_mask", 32'(mask), 0);
    check_output("t1_in_service", 32'(in_service), 0);
    check_output("t1_overflow", 32'(overflow), 0);
    check_output("t1_int_vec", 32'(int_vec), 0);

    // T2 single channel: pending after edge 3, int_req after edge 4
    pulse_irq(5);
    step(2);
    check_output("t2_pending_e3", 32'(pending), 32'h20);
    check_output("t2_req_e3", 32'(int_req), 0);
    step(1);
    check_output("t2_req_e4", 32'(int_req), 1);
    check_output("t2_vec_e4", 32'(int_vec), 5);
    do_ack();
    check_output("t2_pending_ack", 32'(pending), 0);
    check_output("t2_svc_ack", 32'(in_service), 1);
    check_output("t2_req_ack", 32'(int_req), 0);
    do_eret();
    check_output("t2_svc_eret", 32'(in_service), 0);
    check_output("t2_req_eret", 32'(int_req), 0);
    check_output("t2_vec_hold", 32'(int_vec), 5);

    // T3 priority
    irq_in = 8'h44;
    step(1);
    irq_in = '0;
    step(3);
    check_output("t3_req", 32'(int_req), 1);
    check_output("t3_vec", 32'(int_vec), 2);
    check_output("t3_pending", 32'(pending), 32'h44);
    do_ack();
    check_output("t3_pending_ack", 32'(pending), 32'h40);
    check_output("t3_req_ack", 32'(int_req), 0);
    step(1);
    check_output("t3_req_blocked", 32'(int_req), 0);
    do_eret();
    check_output("t3_req_eret", 32'(int_req), 0);
    step(1);
    check_output("t3_req_after", 32'(int_req), 1);
    check_output("t3_vec_after", 32'(int_vec), 6);
    do_ack();
    do_eret();
    check_output("t3_pending_done", 32'(pending), 0);

    // T4 masking
    write_mask(8'h08);
    check_output("t4_mask", 32'(mask), 32'h08);
    pulse_irq(3);
    step(3);
    check_output("t4_pending", 32'(pending), 32'h08);
    check_output("t4_req_masked", 32'(int_req), 0);
    write_mask(8'h00);
    check_output("t4_req_wr", 32'(int_req), 0);
    step(1);
    check_output("t4_req_unmask", 32'(int_req), 1);
    check_output("t4_vec_unmask", 32'(int_vec), 3);
    // mask write alongside ack must not disturb the ack
    int_ack = 1'b1; mask_we = 1'b1; mask_wdata = 8'hFF;
    step(1);
    int_ack = 1'b0; mask_we = 1'b0;
    check_output("t4_pending_ackmask", 32'(pending), 0);
    check_output("t4_svc_ackmask", 32'(in_service), 1);
    check_output("t4_mask_ackmask", 32'(mask), 32'hFF);
    do_eret();
    write_mask(8'h00);

    // T5 overflow and bogus ack
    pulse_irq(1);
    step(1);
    pulse_irq(1);
    step(3);
    check_output("t5_overflow", 32'(overflow), 32'h02);
    check_output("t5_pending", 32'(pending), 32'h02);
    check_output("t5_req", 32'(int_req), 1);
    check_output("t5_vec", 32'(int_vec), 1);
    ovf_clr = 8'h02;
    step(1);
    ovf_clr = '0;
    check_output("t5_overflow_clr", 32'(overflow), 0);
    check_output("t5_pending_kept", 32'(pending), 32'h02);
    do_ack();
    do_eret();
    check_output("t5_svc_idle", 32'(in_service), 0);
    do_ack();
    check_output("t5_bogus_svc", 32'(in_service), 0);
    check_output("t5_bogus_pending", 32'(pending), 0);
    check_output("t5_bogus_req", 32'(int_req), 0);

    // Edge arriving in the same cycle as the ack of that channel
    pulse_irq(0);
    step(3);
    check_output("t5b_req", 32'(int_req), 1);
    check_output("t5b_vec", 32'(int_vec), 0);
    pulse_irq(0);
    step(1);
    do_ack();
    check_output("t5b_pending_set_wins", 32'(pending), 32'h01);
    check_output("t5b_overflow_same", 32'(overflow), 0);
    check_output("t5b_svc", 32'(in_service), 1);
    write_mask(8'hF0);
    do_eret();
    step(1);
    check_output("t5b_req_again", 32'(int_req), 1);

    // Reset in the middle of a handshake, with an ack in flight
    rst = 1'b1; int_ack = 1'b1;
    step(1);
    rst = 1'b0; int_ack = 1'b0;
    check_output("rst_req", 32'(int_req), 0);
    check_output("rst_pending", 32'(pending), 0);
    check_output("rst_svc", 32'(in_service), 0);
    check_output("rst_mask", 32'(mask), 0);
    check_output("rst_vec", 32'(int_vec), 0);
    step(1);
    check_output("rst_req_later", 32'(int_req), 0);
    check_output("rst_svc_later", 32'(in_service), 0);

`ifdef IRQ_NEST_EN
    // T6 nesting
    pulse_irq(4);
    step(3);
    check_output("t6_vec4", 32'(int_vec), 4);
    do_ack();
    pulse_irq(1);
    step(3);
    check_output("t6_req1", 32'(int_req), 1);
    check_output("t6_vec1", 32'(int_vec), 1);
    do_ack();
    pulse_irq(7);
    step(3);
    check_output("t6_pending7", 32'(pending), 32'h80);
    check_output("t6_req7_held", 32'(int_req), 0);
    do_eret();
    step(1);
    check_output("t6_req_one_eret", 32'(int_req), 0);
    check_output("t6_svc_one_eret", 32'(in_service), 1);
    do_eret();
    step(1);
    check_output("t6_req7", 32'(int_req), 1);
    check_output("t6_vec7", 32'(int_vec), 7);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
